mul_arbiter: RTL and testbench
==============================

# mul_arbiter

Round-robin arbiter and sequencer that shares one 64x64 signed Booth multiplier among `NUM_REQ` requesters. It accepts operand pairs over a valid/ready handshake and pulses the multiplier start. It waits for done, with stale-done masking and a timeout, and returns the 128-bit product to the granted requester. It sits between client blocks and the multiplier, and it is the only driver of the multiplier's start and operand inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 200: maximum WAIT cycles before an error response, 2..255.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous reset, active-low.
- `req_valid` in NUM_REQ: request pending, one bit per requester.
- `req_multiplier` in NUM_REQ*64: packed operands; requester i occupies [64i+63:64i].
- `req_multiplicand` in NUM_REQ*64: packed operands, same packing as `req_multiplier`.
- `req_ready` out NUM_REQ: one-hot accept.
- `rsp_valid` out NUM_REQ: one-hot response valid.
- `rsp_ready` in NUM_REQ: response consumed.
- `rsp_result` out 128: product; meaningful only while any `rsp_valid` bit is high.
- `rsp_error` out 1: timeout flag; meaningful only while any `rsp_valid` bit is high.
- `mul_start` out 1: one-cycle start pulse to the multiplier.
- `mul_multiplier` out 64: registered operand, held for the whole operation.
- `mul_multiplicand` out 64: registered operand, held for the whole operation.
- `mul_done` in 1: multiplier done.
- `mul_result` in 128: multiplier product.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- **States:** IDLE, START, WAIT, RESP. Reset enters IDLE.
- **Reset values:**
  - all outputs are 0;
  - `rr_ptr`, grant index, wait counter and result/error registers are 0.
- **IDLE:**
  - `req_ready` is the combinational one-hot of the first set `req_valid` bit, searching from `rr_ptr` upward with wrap.
  - A handshake (`req_valid[g] & req_ready[g]`) latches g, both operands and clears the counter, then goes to START.
  - With no valid request, stay in IDLE.
  - A requester may drop `req_valid` before its handshake; nothing is committed until the handshake.
- **START:** `mul_start`=1 for exactly one cycle, then go to WAIT.
- **WAIT:**
  - The counter increments every cycle.
  - `mul_done` is ignored in the first WAIT cycle (stale done from the previous op).
  - From the second WAIT cycle on, `mul_done`=1 latches `mul_result`, sets error=0 and goes to RESP.
  - If the counter reaches `TIMEOUT` first, latch result=0, set error=1 and go to RESP.
  - When done and timeout fall in the same cycle, done wins.
- **RESP:**
  - `rsp_valid[g]`=1, with `rsp_result`/`rsp_error` held stable until `rsp_ready[g]`.
  - On that cycle, `rr_ptr` <= (g+1) mod NUM_REQ and the state goes to IDLE.
  - `rsp_ready` bits other than g are ignored.
- **Round-robin:** `rr_ptr` advances only on response completion, so the most recent winner becomes lowest priority.
- **Outputs outside IDLE:** `req_ready` is all-zero in every state other than IDLE, so new requests are not accepted while busy.
- **Operand outputs:** `mul_multiplier`/`mul_multiplicand` change only on an IDLE handshake.
- **Reset mid-operation:** abort immediately and issue no response. The multiplier is not restarted; the next op masks its stale done.

## Timing
- Handshake in cycle T; `mul_start` high in T+1; WAIT starts at T+2; the earliest accepted `mul_done` is at T+3.
- `mul_done` sampled high in cycle D gives `rsp_valid` from D+1. Minimum handshake-to-response latency is 4 cycles.
- `rsp_ready` in cycle R gives IDLE at R+1; the next handshake is possible in R+1.
- A timeout response appears at T+2+TIMEOUT.
- `rsp_valid` and `busy` are registered; `req_ready` is combinational from `req_valid`, `rr_ptr` and state.

## Test plan
- **Single request:** reset; req0 with multiplier 3, multiplicand 5. Expect `req_ready`=0001 in the same cycle, `mul_start` one pulse, then `rsp_valid`=0001 with `rsp_result`=15 and `rsp_error`=0; `busy` returns to 0.
- **Signed pass-through:** req2 with -2 × 7. Expect `rsp_result`=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF2 on `rsp_valid`=0100.
- **Fairness:** `req_valid`=1111 held for 8 operations. Grant order is 0,1,2,3,0,1,2,3, and no `req_ready` appears outside IDLE.
- **Stale done:** the model holds `mul_done`=1 through START and the first WAIT cycle, then drops it for 10 cycles and raises it again. The result is captured only on the later done.
- **Timeout:** `TIMEOUT`=20 and `mul_done` held 0. Expect `rsp_error`=1 and `rsp_result`=0 at T+22; hold `rsp_ready` low 5 cycles and check the outputs stay stable.
- **Reset mid-WAIT:** assert `reset_n`=0 in WAIT. Expect all outputs 0 immediately and no `rsp_valid`; after release, a new req1 completes correctly.

Source files
------------

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one signed 64x64 multiplier among NUM_REQ clients.
// Latency: handshake to response >= 4 cycles; timeout response TIMEOUT+2 cycles after handshake.
// Backpressure: one op in flight; req_ready low while busy; response held until rsp_ready[g].
module mul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 200
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*64-1:0] req_multiplier,
   input  logic [NUM_REQ*64-1:0] req_multiplicand,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [NUM_REQ-1:0]    rsp_valid,
   input  logic [NUM_REQ-1:0]    rsp_ready,
   output logic [127:0]          rsp_result,
   output logic                  rsp_error,
   output logic                  mul_start,
   output logic [63:0]           mul_multiplier,
   output logic [63:0]           mul_multiplicand,
   input  logic                  mul_done,
   input  logic [127:0]          mul_result,
   output logic                  busy
);
   localparam int IW = $clog2(NUM_REQ);
   localparam logic [IW:0]        NR_W     = (IW+1)'(NUM_REQ);
   localparam logic [IW-1:0]      LAST_IDX = IW'(NUM_REQ-1);
   localparam logic [7:0]         TMO_LAST = 8'(TIMEOUT-1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

   state_t        state;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] grant;
   logic [7:0]    wait_cnt;

   logic [IW-1:0] sel_idx;
   logic [IW-1:0] cand;
   logic [IW:0]   sum;
   logic          found;
   logic [63:0]   sel_mr;
   logic [63:0]   sel_mc;

   // Search upward from rr_ptr with wrap; the first valid requester wins.
   always_comb begin
      req_ready = '0;
      sel_idx   = '0;
      sel_mr    = '0;
      sel_mc    = '0;
      found     = 1'b0;
      sum       = '0;
      cand      = '0;
      if (state == IDLE) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(i);
            if (sum >= NR_W) sum = sum - NR_W;
            cand = sum[IW-1:0];
            if (!found && req_valid[cand]) begin
               found           = 1'b1;
               req_ready[cand] = 1'b1;
               sel_idx         = cand;
               sel_mr          = req_multiplier[{cand, 6'd0} +: 64];
               sel_mc          = req_multiplicand[{cand, 6'd0} +: 64];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         rr_ptr           <= '0;
         grant            <= '0;
         wait_cnt         <= '0;
         rsp_valid        <= '0;
         rsp_result       <= '0;
         rsp_error        <= 1'b0;
         mul_start        <= 1'b0;
         mul_multiplier   <= '0;
         mul_multiplicand <= '0;
         busy             <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  grant            <= sel_idx;
                  mul_multiplier   <= sel_mr;
                  mul_multiplicand <= sel_mc;
                  wait_cnt         <= '0;
                  mul_start        <= 1'b1;
                  busy             <= 1'b1;
                  state            <= START;
               end
            end
            START: begin
               mul_start <= 1'b0;
               state     <= WAIT;
            end
            WAIT: begin
               wait_cnt <= wait_cnt + 8'd1;
               // A done seen in the first WAIT cycle belongs to the previous operation.
               if (mul_done && (wait_cnt != 8'd0)) begin
                  rsp_result <= mul_result;
                  rsp_error  <= 1'b0;
                  rsp_valid  <= ONE_HOT0 << grant;
                  state      <= RESP;
               end else if (wait_cnt == TMO_LAST) begin
                  rsp_result <= '0;
                  rsp_error  <= 1'b1;
                  rsp_valid  <= ONE_HOT0 << grant;
                  state      <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready[grant]) begin
                  rsp_valid <= '0;
                  rr_ptr    <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: randomized scoreboard bench with a behavioural multiplier and round-robin model.
// Stimulus pushes expected responses; a monitor pops them when rsp_valid appears.
// The monitor also applies random rsp_ready backpressure and checks response stability.
module tb_mul_arbiter;
   localparam int N   = 4;
   localparam int TMO = 20;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [N-1:0]    req_valid;
   logic [N*64-1:0] req_multiplier;
   logic [N*64-1:0] req_multiplicand;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    rsp_valid;
   logic [N-1:0]    rsp_ready;
   logic [127:0]    rsp_result;
   logic            rsp_error;
   logic            mul_start;
   logic [63:0]     mul_multiplier;
   logic [63:0]     mul_multiplicand;
   logic            mul_done;
   logic [127:0]    mul_result;
   logic            busy;

   typedef struct {
      int           g;
      logic [127:0] res;
      logic         err;
      int           cyc;
      int           hold;
   } exp_t;

   exp_t scb[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   model_ptr = 0;
   int   cur_lat = 2;
   bit   cur_stale = 1'b0;
   int   n_start = 0;
   int   n_issue = 0;

   mul_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .req_valid        (req_valid),
      .req_multiplier   (req_multiplier),
      .req_multiplicand (req_multiplicand),
      .req_ready        (req_ready),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_result       (rsp_result),
      .rsp_error        (rsp_error),
      .mul_start        (mul_start),
      .mul_multiplier   (mul_multiplier),
      .mul_multiplicand (mul_multiplicand),
      .mul_done         (mul_done),
      .mul_result       (mul_result),
      .busy             (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [127:0] smul(input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] sa;
      logic signed [127:0] sb;
      sa = {{64{a[63]}}, a};
      sb = {{64{b[63]}}, b};
      return sa * sb;
   endfunction

   function automatic logic [63:0] rnd_op();
      case ($urandom_range(0, 5))
         0:       return 64'h8000_0000_0000_0000;
         1:       return '1;
         2:       return 64'd0;
         3:       return 64'(-int'($urandom_range(1, 100)));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   // Behavioural multiplier: product of the operands seen with mul_start, delivered cur_lat
   // cycles later; optional stale done during START and the first WAIT cycle with junk data.
   initial begin : mul_model
      int          s;
      int          done_at;
      bit          stl;
      bit          prev;
      logic [63:0] a;
      logic [63:0] b;
      s = -100; done_at = -1; stl = 1'b0; prev = 1'b0; a = '0; b = '0;
      mul_done = 1'b0;
      mul_result = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            done_at = -1; stl = 1'b0; prev = 1'b0; mul_done = 1'b0;
         end else begin
            if (mul_start) begin
               check("mul_start_single_cycle", 128'(prev), 128'd0);
               n_start++;
               s = cyc; a = mul_multiplier; b = mul_multiplicand; stl = cur_stale;
               done_at = (cur_lat > 0) ? cyc + cur_lat : -1;
            end
            prev = mul_start;
            if (done_at >= 0 && cyc == done_at) begin
               mul_done = 1'b1; mul_result = smul(a, b);
            end else if (stl && (cyc == s || cyc == s + 1)) begin
               mul_done = 1'b1; mul_result = {$urandom, $urandom, $urandom, $urandom};
            end else begin
               mul_done = 1'b0; mul_result = {$urandom, $urandom, $urandom, $urandom};
            end
         end
      end
   end

   initial begin : monitor
      int           ph;
      int           hold;
      int           g;
      exp_t         e;
      logic [N-1:0] sv;
      logic [127:0] sr;
      logic         se;
      ph = 0; hold = 0; g = 0; sv = '0; sr = '0; se = 1'b0;
      rsp_ready = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            ph = 0; rsp_ready = '0;
         end else begin
            if (busy) check("req_ready_while_busy", 128'(req_ready), 128'd0);
            if (ph == 2) begin
               check("rsp_valid_cleared", 128'(rsp_valid), 128'd0);
               check("busy_after_rsp", 128'(busy), 128'd0);
               rsp_ready = '0;
               ph = 0;
            end else if (ph == 1) begin
               check("rsp_valid_stable", 128'(rsp_valid), 128'(sv));
               check("rsp_result_stable", rsp_result, sr);
               check("rsp_error_stable", 128'(rsp_error), 128'(se));
            end else if (rsp_valid != '0) begin
               if (scb.size() == 0) begin
                  check("unexpected_rsp", 128'(rsp_valid), 128'd0);
                  rsp_ready = '1;
                  ph = 2;
               end else begin
                  e = scb.pop_front();
                  g = e.g;
                  check("rsp_valid_onehot", 128'(rsp_valid), 128'(1) << g);
                  check("rsp_result", rsp_result, e.res);
                  check("rsp_error", 128'(rsp_error), 128'(e.err));
                  check("rsp_cycle", 128'(cyc), 128'(e.cyc));
                  check("busy_in_rsp", 128'(busy), 128'd1);
                  sv = rsp_valid; sr = rsp_result; se = rsp_error;
                  hold = e.hold;
                  ph = 1;
               end
            end
            if (ph == 1) begin
               if (hold > 0) begin
                  rsp_ready = N'($urandom) & ~(N'(1) << g);
                  hold--;
               end else begin
                  rsp_ready = N'($urandom) | (N'(1) << g);
                  ph = 2;
               end
            end
         end
      end
   end

   // lat = 0 means the multiplier never answers (timeout expected).
   task automatic issue(input logic [N-1:0] mask, input bit keep, input int lat, input bit stale,
                        input int hold, input bit use_fix, input logic [63:0] fa,
                        input logic [63:0] fb);
      int          g;
      int          k;
      logic [63:0] a;
      logic [63:0] b;
      exp_t        e;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (busy && k < 300);
      if (busy) check("idle_wait_expired", 128'(busy), 128'd0);
      g = model_ptr;
      for (int i = 0; i < N; i++) begin
         g = (model_ptr + i) % N;
         if (mask[g]) break;
      end
      for (int i = 0; i < N; i++) begin
         req_multiplier[i*64 +: 64]   = rnd_op();
         req_multiplicand[i*64 +: 64] = rnd_op();
      end
      if (use_fix) begin
         req_multiplier[g*64 +: 64]   = fa;
         req_multiplicand[g*64 +: 64] = fb;
      end
      req_valid = mask;
      cur_lat = lat;
      cur_stale = stale;
      #1;
      check("req_ready_grant", 128'(req_ready), 128'(1) << g);
      a = req_multiplier[g*64 +: 64];
      b = req_multiplicand[g*64 +: 64];
      e.g    = g;
      e.err  = (lat == 0);
      e.res  = (lat == 0) ? 128'd0 : smul(a, b);
      e.cyc  = (lat == 0) ? cyc + 2 + TMO : cyc + lat + 2;
      e.hold = hold;
      scb.push_back(e);
      n_issue++;
      model_ptr = (g + 1) % N;
      @(negedge clk);
      if (!keep) req_valid = N'($urandom);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [N-1:0] mask;
      int           lat;
      int           k;
      reset_n = 1'b0;
      req_valid = '0;
      req_multiplier = '0;
      req_multiplicand = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", 128'(busy), 128'd0);
      check("reset_rsp_valid", 128'(rsp_valid), 128'd0);
      check("reset_req_ready", 128'(req_ready), 128'd0);
      check("reset_mul_start", 128'(mul_start), 128'd0);
      check("reset_operands", {mul_multiplier, mul_multiplicand}, 128'd0);
      check("reset_rsp_data", {rsp_result[126:0], rsp_error}, 128'd0);
      @(negedge clk);
      reset_n = 1'b1;

      issue(4'b0001, 1'b0, 2, 1'b0, 0, 1'b1, 64'd3, 64'd5);
      issue(4'b0100, 1'b0, 3, 1'b0, 1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd7);
      issue(4'b1000, 1'b0, 0, 1'b0, 5, 1'b0, '0, '0);
      for (int i = 0; i < 8; i++)
         issue(4'b1111, 1'b1, int'($urandom_range(2, 8)), 1'b0, int'($urandom_range(0, 2)),
               1'b0, '0, '0);
      issue(4'b0010, 1'b0, 12, 1'b1, 0, 1'b0, '0, '0);
      issue(4'b0001, 1'b0, TMO, 1'b0, 0, 1'b0, '0, '0);
      issue(4'b0110, 1'b0, TMO - 1, 1'b1, 1, 1'b0, '0, '0);
      for (int i = 0; i < 40; i++) begin
         mask = N'($urandom_range(1, 15));
         lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 10));
         issue(mask, 1'($urandom_range(0, 1)), lat, 1'($urandom_range(0, 3) == 0),
               int'($urandom_range(0, 3)), 1'b0, '0, '0);
      end

      // Abort an operation in WAIT; no response may follow.
      issue(4'b0001, 1'b0, 0, 1'b0, 0, 1'b0, '0, '0);
      req_valid = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midrst_busy", 128'(busy), 128'd0);
      check("midrst_rsp_valid", 128'(rsp_valid), 128'd0);
      check("midrst_req_ready", 128'(req_ready), 128'd0);
      check("midrst_mul_start", 128'(mul_start), 128'd0);
      check("midrst_operands", {mul_multiplier, mul_multiplicand}, 128'd0);
      check("midrst_rsp_data", {rsp_result[126:0], rsp_error}, 128'd0);
      scb.delete(scb.size() - 1);
      model_ptr = 0;
      repeat (3) begin
         @(negedge clk);
         check("midrst_no_rsp", 128'(rsp_valid), 128'd0);
      end
      reset_n = 1'b1;
      issue(4'b0010, 1'b0, 5, 1'b1, 1, 1'b0, '0, '0);

      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (busy && k < 300);
      req_valid = '0;
      check("final_idle", 128'(busy), 128'd0);
      repeat (5) @(negedge clk);
      check("scoreboard_drained", 128'(scb.size()), 128'd0);
      check("start_count", 128'(n_start), 128'(n_issue));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
